// File: rtl/multi_sprite_core.sv
// multi_sprite_core: overlays up to NUM_SPR 32x32 four-colour sprites on a
// pixel stream with a fixed two-clock latency.
// Optional feature macro: MULTI_SPRITE_MIRROR_EN (horizontal mirror per sprite).

// One sprite: position/enable/palette registers, pattern RAM, hit test and
// stage-2 palette lookup. Outputs are the stage-2 candidate for this sprite.
module multi_sprite_lane #(
  parameter int CD         = 12,
  parameter int ADDR_WIDTH = 10,
  parameter int KEY_COLOR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ram_we,
  input  logic                  reg_we,
  input  logic [2:0]            reg_sel,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [31:0]           wr_data,
  input  logic [10:0]           x,
  input  logic [10:0]           y,
  input  logic                  commit,
  output logic                  opaque,
  output logic [CD-1:0]         colour
);
  logic [10:0]           x0_sh, y0_sh, x0, y0;
  logic                  en;
  logic [CD-1:0]         pal1, pal2, pal3;
  logic [1:0]            mem [2**ADDR_WIDTH];
  logic [11:0]           dx, dy;
  logic [4:0]            col;
  logic                  hit, hit_q;
  logic [1:0]            code_q;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  unused_bits;

  assign unused_bits = ^wr_data[31:11];

`ifdef MULTI_SPRITE_MIRROR_EN
  logic mir;
`endif

  // Register file; the active position follows the shadow only at frame commit,
  // so a same-cycle shadow write is seen one frame later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x0_sh <= '0; y0_sh <= '0; x0 <= '0; y0 <= '0; en <= 1'b0;
      pal1 <= '0; pal2 <= '0; pal3 <= '0;
`ifdef MULTI_SPRITE_MIRROR_EN
      mir <= 1'b0;
`endif
    end else begin
      if (commit) begin
        x0 <= x0_sh;
        y0 <= y0_sh;
      end
      if (reg_we) begin
        case (reg_sel)
          3'd1: x0_sh <= wr_data[10:0];
          3'd2: y0_sh <= wr_data[10:0];
          3'd3: en    <= wr_data[0];
          3'd4: pal1  <= wr_data[CD-1:0];
          3'd5: pal2  <= wr_data[CD-1:0];
          3'd6: pal3  <= wr_data[CD-1:0];
`ifdef MULTI_SPRITE_MIRROR_EN
          3'd7: mir   <= wr_data[0];
`endif
          default: ;
        endcase
      end
    end
  end

  // Hit test in 12-bit two's complement; positions near 2047 do not wrap.
  assign dx  = {1'b0, x} - {1'b0, x0};
  assign dy  = {1'b0, y} - {1'b0, y0};
  assign hit = en && (dx[11:5] == 7'd0) && (dy[11:5] == 7'd0);
`ifdef MULTI_SPRITE_MIRROR_EN
  assign col = mir ? ~dx[4:0] : dx[4:0];
`else
  assign col = dx[4:0];
`endif
  assign rd_addr = ADDR_WIDTH'({dy[4:0], col});

  // Pattern RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[wr_addr] <= wr_data[1:0];
  end

  // Stage 1: synchronous read (old data on same-address write) plus hit flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      code_q <= mem[rd_addr];
      hit_q  <= hit;
    end
  end

  // Stage 2 palette lookup; code 0 and the key colour are transparent.
  always_comb begin
    colour = '0;
    case (code_q)
      2'd1:    colour = pal1;
      2'd2:    colour = pal2;
      2'd3:    colour = pal3;
      default: colour = '0;
    endcase
  end
  assign opaque = hit_q && (code_q != 2'd0) && (colour != CD'(KEY_COLOR));
endmodule

module multi_sprite_core #(
  parameter int CD         = 12,
  parameter int NUM_SPR    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int KEY_COLOR  = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          cs,
  input  logic          write,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb
);
  logic                           wr_en, commit, byp, byp_q, found;
  logic [CD-1:0]                  si_q, win_col;
  logic [NUM_SPR-1:0]             lane_opq;
  logic [NUM_SPR-1:0][CD-1:0]     lane_col;

  assign wr_en  = cs & write;
  assign commit = (x == 11'd0) && (y == 11'd0);

  for (genvar i = 0; i < NUM_SPR; i++) begin : g_lane
    multi_sprite_lane #(.CD(CD), .ADDR_WIDTH(ADDR_WIDTH), .KEY_COLOR(KEY_COLOR)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .ram_we (wr_en & ~addr[13] & (addr[12:10] == 3'(i))),
      .reg_we (wr_en &  addr[13] & (addr[6:3]   == 4'(i))),
      .reg_sel(addr[2:0]),
      .wr_addr(addr[ADDR_WIDTH-1:0]),
      .wr_data(wr_data),
      .x      (x),
      .y      (y),
      .commit (commit),
      .opaque (lane_opq[i]),
      .colour (lane_col[i])
    );
  end

  // Global bypass flag; the sprite index field is ignored for register 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                     byp <= 1'b0;
    else if (wr_en && addr[13] && addr[2:0] == 3'd0) byp <= wr_data[0];
  end

  // Stage 1: stream pixel and bypass flag travel alongside the RAM reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      si_q  <= '0;
      byp_q <= 1'b0;
    end else begin
      si_q  <= si_rgb;
      byp_q <= byp;
    end
  end

  // Priority select: scanning downward leaves the lowest opaque index.
  always_comb begin
    found   = 1'b0;
    win_col = '0;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (lane_opq[i]) begin
        found   = 1'b1;
        win_col = lane_col[i];
      end
    end
  end

  // Stage 2 output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) so_rgb <= '0;
    else        so_rgb <= (byp_q || !found) ? si_q : win_col;
  end
endmodule

// File: tb/tb_multi_sprite_core.sv
// Scoreboard bench for multi_sprite_core: directed scenarios plus randomized
// traffic checked against a frame-level reference model.
module tb_multi_sprite_core;
  localparam int CD = 12;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [10:0]   x, y;
  logic          cs, write;
  logic [13:0]   addr;
  logic [31:0]   wr_data;
  logic [CD-1:0] si_rgb, so_rgb;

  always #5 clk = ~clk;

  multi_sprite_core #(.CD(CD), .NUM_SPR(NS), .ADDR_WIDTH(10), .KEY_COLOR(0)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .cs(cs), .write(write),
    .addr(addr), .wr_data(wr_data), .si_rgb(si_rgb), .so_rgb(so_rgb)
  );

  // reference model state
  logic [1:0]  m_ram [NS][1024];
  int          m_x0s[NS], m_y0s[NS], m_x0[NS], m_y0[NS];
  bit          m_en[NS], m_mir[NS];
  logic [11:0] m_pal[NS][4];
  bit          m_byp;

  typedef struct {
    bit                   vld;
    int                   e;
    logic [11:0]          si;
    bit                   byp;
    logic [NS-1:0]        hit;
    logic [NS-1:0][1:0]   code;
    bit                   has_lit;
    logic [11:0]          lit;
    int                   id;
  } rec_t;
  typedef struct { int e; logic [11:0] exp; int id; } ent_t;

  ent_t sbq[$];
  rec_t pend;
  int   edge_n = 0;
  int   n_chk = 0, n_fail = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic model_reset();
    m_byp = 0;
    for (int s = 0; s < NS; s++) begin
      m_x0s[s] = 0; m_y0s[s] = 0; m_x0[s] = 0; m_y0[s] = 0;
      m_en[s] = 0; m_mir[s] = 0;
      for (int c = 0; c < 4; c++) m_pal[s][c] = '0;
    end
  endtask

  // What the sprite engine sees for a pixel: which sprites cover it and with which code.
  function automatic rec_t sample(int xi, int yi, logic [11:0] si);
    rec_t r;
    int dx, dy, col;
    r.vld = 1; r.e = 0; r.si = si; r.byp = m_byp; r.hit = '0; r.code = '0;
    r.has_lit = 0; r.lit = '0; r.id = 0;
    for (int s = 0; s < NS; s++) begin
      dx = xi - m_x0[s];
      dy = yi - m_y0[s];
      if (m_en[s] && dx >= 0 && dx < 32 && dy >= 0 && dy < 32) begin
        col = dx;
`ifdef MULTI_SPRITE_MIRROR_EN
        if (m_mir[s]) col = 31 - dx;
`endif
        r.hit[s]  = 1'b1;
        r.code[s] = m_ram[s][dy*32 + col];
      end
    end
    return r;
  endfunction

  // Colour the pixel using the palette in force one clock after sampling.
  function automatic logic [11:0] resolve(rec_t r);
    logic [11:0] res;
    bit done;
    res = r.si; done = 0;
    if (!r.byp)
      for (int s = 0; s < NS; s++)
        if (!done && r.hit[s] && r.code[s] != 0 && m_pal[s][r.code[s]] != 12'd0) begin
          res  = m_pal[s][r.code[s]];
          done = 1;
        end
    return res;
  endfunction

  task automatic apply(int xi, int yi, bit c, bit w, logic [13:0] a, logic [31:0] d);
    int s, r;
    if (xi == 0 && yi == 0)
      for (int k = 0; k < NS; k++) begin m_x0[k] = m_x0s[k]; m_y0[k] = m_y0s[k]; end
    if (c && w) begin
      if (!a[13]) begin
        s = int'(a[12:10]);
        if (s < NS) m_ram[s][a[9:0]] = d[1:0];
      end else begin
        s = int'(a[6:3]); r = int'(a[2:0]);
        if (r == 0) m_byp = d[0];
        else if (s < NS)
          case (r)
            1: m_x0s[s] = int'(d[10:0]);
            2: m_y0s[s] = int'(d[10:0]);
            3: m_en[s]  = d[0];
            4: m_pal[s][1] = d[11:0];
            5: m_pal[s][2] = d[11:0];
            6: m_pal[s][3] = d[11:0];
            default: m_mir[s] = d[0];
          endcase
      end
    end
  endtask

  // One clock of stimulus; the previous pixel's expectation is queued here.
  task automatic step(input int xi, input int yi, input logic [11:0] si, input bit c, input bit w,
                      input logic [13:0] a, input logic [31:0] d,
                      input bit hl, input logic [11:0] lit, input int id);
    ent_t en;
    @(negedge clk);
    x = 11'(xi); y = 11'(yi); si_rgb = si; cs = c; write = w; addr = a; wr_data = d;
    if (pend.vld) begin
      en.e   = pend.e;
      en.exp = pend.has_lit ? pend.lit : resolve(pend);
      en.id  = pend.id;
      sbq.push_back(en);
    end
    pend = sample(xi, yi, si);
    pend.e = edge_n + 1; pend.has_lit = hl; pend.lit = lit; pend.id = id;
    apply(xi, yi, c, w, a, d);
  endtask

  function automatic logic [13:0] ra(int s, int r);
    return {1'b1, 6'd0, 4'(s), 3'(r)};
  endfunction
  function automatic logic [13:0] pa(int s, int p);
    return {1'b0, 3'(s), 10'(p)};
  endfunction

  task automatic wr(logic [13:0] a, logic [31:0] d);
    step(500, 500, 12'h000, 1, 1, a, d, 0, 12'h0, 0);
  endtask
  task automatic pix(int xi, int yi, logic [11:0] si);
    step(xi, yi, si, 0, 0, 14'h0, 32'h0, 0, 12'h0, 0);
  endtask
  task automatic probe(int xi, int yi, logic [11:0] si, logic [11:0] lit, int id);
    step(xi, yi, si, 0, 0, 14'h0, 32'h0, 1, lit, id);
  endtask

  // monitor: every queued pixel must appear exactly two clocks after it entered
  always @(negedge clk) begin
    ent_t e;
    while (sbq.size() > 0 && sbq[0].e + 1 <= edge_n) begin
      e = sbq.pop_front();
      n_chk++;
      if (e.e + 1 != edge_n || so_rgb !== e.exp) begin
        n_fail++;
        $display("FAIL %s%0d edge %0d: so_rgb=%h required %h", (e.id == 0) ? "rnd" : "dir",
                 e.id, e.e, so_rgb, e.exp);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int rr, rs, xi, yi, s, rg;
    bit c, w;
    logic [13:0] a;
    logic [31:0] d;
    pend.vld = 0;
    model_reset();
    reset = 1'b0; x = 11'd500; y = 11'd500; cs = 0; write = 0; addr = '0; wr_data = '0;
    si_rgb = 12'h5A5;
    repeat (3) @(negedge clk);
    n_chk++;
    if (so_rgb !== 12'h000) begin n_fail++; $display("FAIL rst_hold: so_rgb=%h required 000", so_rgb); end
    reset = 1'b1;

    // pass-through after reset
    probe(500, 500, 12'h5A5, 12'h5A5, 1);
    probe(500, 500, 12'h3C3, 12'h3C3, 2);

    // clear all pattern RAM so the directed scenarios are deterministic
    for (int sp = 0; sp < NS; sp++)
      for (int p = 0; p < 1024; p++) wr(pa(sp, p), 32'h0);

    // single sprite at (100,50)
    wr(ra(0, 1), 100); wr(ra(0, 2), 50); wr(ra(0, 3), 1); wr(ra(0, 4), 12'hF00);
    wr(pa(0, 0), 1);
    pix(0, 0, 12'h000);
    probe(100, 50, 12'h123, 12'hF00, 3);
    probe(99, 50, 12'h124, 12'h124, 4);
    probe(132, 50, 12'h125, 12'h125, 5);
    probe(131, 50, 12'h126, 12'h126, 6);

    // priority between overlapping sprites
    wr(ra(0, 1), 200); wr(ra(0, 2), 200); wr(ra(0, 4), 12'h0F0);
    wr(ra(1, 1), 200); wr(ra(1, 2), 200); wr(ra(1, 3), 1); wr(ra(1, 4), 12'h00F);
    wr(pa(1, 0), 1);
    pix(0, 0, 12'h000);
    probe(200, 200, 12'h321, 12'h0F0, 7);
    wr(ra(0, 3), 0);
    probe(200, 200, 12'h321, 12'h00F, 8);

    // shadow/commit timing
    step(5, 100, 12'h0, 1, 1, ra(1, 1), 300, 0, 12'h0, 0);
    probe(200, 200, 12'h321, 12'h00F, 9);
    probe(300, 200, 12'h321, 12'h321, 10);
    pix(0, 0, 12'h000);
    probe(300, 200, 12'h321, 12'h00F, 11);
    step(0, 0, 12'h0, 1, 1, ra(1, 1), 400, 0, 12'h0, 0);
    probe(300, 200, 12'h322, 12'h00F, 12);
    probe(400, 200, 12'h322, 12'h322, 13);
    pix(0, 0, 12'h000);
    probe(400, 200, 12'h323, 12'h00F, 14);

    // bypass (index field ignored)
    wr(ra(0, 0), 1);
    probe(400, 200, 12'h246, 12'h246, 15);
    wr(ra(5, 0), 0);
    probe(400, 200, 12'h247, 12'h00F, 16);

    // mirror
    wr(ra(2, 1), 0); wr(ra(2, 2), 0); wr(ra(2, 3), 1); wr(ra(2, 5), 12'hABC); wr(ra(2, 7), 1);
    wr(pa(2, 31), 2);
    pix(0, 0, 12'h000);
`ifdef MULTI_SPRITE_MIRROR_EN
    probe(0, 0, 12'h111, 12'hABC, 17);
`else
    probe(0, 0, 12'h111, 12'h111, 17);
`endif

    // right-edge clipping without wrap
    wr(ra(3, 1), 2040); wr(ra(3, 2), 10); wr(ra(3, 3), 1); wr(ra(3, 4), 12'h777);
    for (int p = 0; p < 32; p++) wr(pa(3, p), 1);
    pix(0, 0, 12'h000);
    for (int xx = 2040; xx < 2048; xx++) probe(xx, 10, 12'h0AA, 12'h777, 18);
    for (int xx = 0; xx < 24; xx++) probe(xx, 10, 12'h0BB, 12'h0BB, 19);

    // reset mid-frame: output drops at once, registers clear, RAM kept
    @(negedge clk);
    #2;
    reset = 1'b0;
    sbq.delete();
    pend.vld = 0;
    model_reset();
    #1;
    n_chk++;
    if (so_rgb !== 12'h000) begin n_fail++; $display("FAIL rst_mid: so_rgb=%h required 000", so_rgb); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    probe(2040, 10, 12'h0CC, 12'h0CC, 20);

    // randomized pattern fill then randomized traffic
    for (int sp = 0; sp < NS; sp++)
      for (int p = 0; p < 1024; p++) wr(pa(sp, p), $urandom);
    for (int i = 0; i < 6000; i++) begin
      rr = $urandom_range(0, 99);
      if (rr < 3)      begin xi = 0; yi = 0; end
      else if (rr < 8) begin xi = $urandom_range(2000, 2047); yi = $urandom_range(0, 200); end
      else             begin xi = $urandom_range(0, 240);     yi = $urandom_range(0, 240); end
      c = 0; w = 0; a = 14'($urandom); d = $urandom;
      rs = $urandom_range(0, 99);
      if (rs < 10) begin
        c = 1; w = 1;
        s = $urandom_range(0, 5); rg = $urandom_range(0, 7);
        a = ra(s, rg);
        case (rg)
          0:    d[0] = ($urandom_range(0, 3) == 0);
          1, 2: d[10:0] = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(1990, 2047))
                                                      : 11'($urandom_range(0, 200));
          3:    d[0] = ($urandom_range(0, 3) != 0);
          4, 5, 6: if ($urandom_range(0, 5) == 0) d[11:0] = 12'h000;
          default: ;
        endcase
      end else if (rs < 25) begin
        c = 1; w = 1; a = pa($urandom_range(0, 7), $urandom_range(0, 1023));
      end else if (rs < 30) begin
        c = ($urandom_range(0, 1) == 1); w = !c; a = ra($urandom_range(0, 3), $urandom_range(0, 7));
      end
      step(xi, yi, 12'($urandom), c, w, a, d, 0, 12'h0, 0);
    end

    repeat (3) pix(500, 500, 12'h000);
    repeat (3) @(negedge clk);
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d pixels still queued, required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
